// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS.cc BCD stopwatch datapath.
// Digit indices give the nibble position of each digit inside the packed 24-bit digits bus.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned BCD_MAX    = 9;
  localparam int unsigned SEX_MAX    = 5;

  localparam int unsigned IDX_CC_O = 0;
  localparam int unsigned IDX_CC_T = 1;
  localparam int unsigned IDX_SS_O = 2;
  localparam int unsigned IDX_SS_T = 3;
  localparam int unsigned IDX_MM_O = 4;
  localparam int unsigned IDX_MM_T = 5;

  // Value of 00:00.01, the only state from which a down tick lands on zero.
  localparam logic [23:0] ONE_CENTI = 24'h000001;

  // Roll-over value of the digit at a given position.
  function automatic int unsigned digit_max(input int unsigned idx, input int unsigned mm_max);
    int unsigned m;
    m = BCD_MAX;
    if (idx == IDX_SS_T) m = SEX_MAX;
    if (idx == IDX_MM_T) m = mm_max;
    return m;
  endfunction

  // Clamp an out-of-range switch digit to the largest legal value.
  function automatic bcd_t sat_digit(input bcd_t v, input bcd_t max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit cell with configurable roll-over value, counting up or down.
// Carry/borrow outputs are combinational so a six-digit ripple settles in one cycle.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_VAL = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic dir,
  input  logic carry_in,
  input  logic borrow_in,
  input  logic clr,
  input  logic ld,
  input  bcd_t ld_val,
  output bcd_t value,
  output logic carry_out,
  output logic borrow_out
);

  localparam bcd_t MAX_BCD = bcd_t'(MAX_VAL);

  bcd_t value_reg;
  bcd_t value_next;

  always_comb begin
    value_next = value_reg;
    if (clr) begin
      value_next = '0;
    end else if (ld) begin
      value_next = ld_val;
    end else if (en) begin
      if (!dir && carry_in) begin
        value_next = (value_reg >= MAX_BCD) ? '0 : value_reg + 4'd1;
      end else if (dir && borrow_in) begin
        value_next = (value_reg == '0) ? MAX_BCD : value_reg - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  assign value      = value_reg;
  assign carry_out  = !dir && carry_in && (value_reg >= MAX_BCD);
  assign borrow_out = dir && borrow_in && (value_reg == '0);

endmodule

// File: rtl/stopwatch_counter.sv
// BCD stopwatch datapath: six chained digit cells, preset saturation, zero
// detect and the registered wrap/expired pulses.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MM_MAX_TENS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clks100,
  input  logic        clr,
  input  logic        ld,
  input  logic        dir,
  input  logic        state,
  input  logic [15:0] preset,
  output logic [23:0] digits,
  output logic        at_zero,
  output logic        wrap,
  output logic        expired
);

  logic [NUM_DIGITS:0] carry_chain;
  logic [NUM_DIGITS:0] borrow_chain;
  bcd_t                digit_val [NUM_DIGITS];
  bcd_t                ld_val    [NUM_DIGITS];
  logic                count_en;
  logic                wrap_reg;
  logic                wrap_next;
  logic                expired_reg;
  logic                expired_next;

  assign carry_chain[0]  = 1'b1;
  assign borrow_chain[0] = 1'b1;

  // A borrow out of the top digit means every digit is zero while counting
  // down; that is exactly the hold-at-zero condition.
  assign count_en = clks100 && state && !clr && !ld && !borrow_chain[NUM_DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi < 2) begin : g_cc_ld
        assign ld_val[gi] = '0;
      end else begin : g_sw_ld
        assign ld_val[gi] = sat_digit(preset[DIGIT_W*(gi-2) +: DIGIT_W],
                                      bcd_t'(digit_max(gi, MM_MAX_TENS)));
      end

      bcd_digit #(
        .MAX_VAL(digit_max(gi, MM_MAX_TENS))
      ) u_digit (
        .clk       (clk),
        .rst       (rst),
        .en        (count_en),
        .dir       (dir),
        .carry_in  (carry_chain[gi]),
        .borrow_in (borrow_chain[gi]),
        .clr       (clr),
        .ld        (ld),
        .ld_val    (ld_val[gi]),
        .value     (digit_val[gi]),
        .carry_out (carry_chain[gi+1]),
        .borrow_out(borrow_chain[gi+1])
      );

      assign digits[DIGIT_W*gi +: DIGIT_W] = digit_val[gi];
    end
  endgenerate

  always_comb begin
    wrap_next    = count_en && !dir && carry_chain[NUM_DIGITS];
    expired_next = count_en && dir && (digits == ONE_CENTI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_reg    <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      wrap_reg    <= wrap_next;
      expired_reg <= expired_next;
    end
  end

  assign wrap    = wrap_reg;
  assign expired = expired_reg;
  assign at_zero = (digits == '0);

endmodule

// File: tb/tb_stopwatch_counter.sv
// Randomized self-checking bench: the reference model tracks elapsed time as a
// plain centisecond count and converts it to BCD only for comparison.
module tb_stopwatch_counter;

  localparam int MMT      = 5;
  localparam int MAX_CS   = (MMT * 10 + 9) * 6000 + 5999;

  logic        clk = 1'b0;
  logic        rst, clks100, clr, ld, dir, sw_state;
  logic [15:0] preset;
  logic [23:0] digits;
  logic        at_zero, wrap, expired;

  int checks = 0;
  int errors = 0;
  int model_cs = 0;
  bit model_wrap = 0;
  bit model_exp = 0;
  int wrap_seen = 0;
  int exp_seen = 0;

  stopwatch_counter #(.MM_MAX_TENS(MMT)) dut (
    .clk(clk), .rst(rst), .clks100(clks100), .clr(clr), .ld(ld), .dir(dir),
    .state(sw_state), .preset(preset), .digits(digits), .at_zero(at_zero),
    .wrap(wrap), .expired(expired)
  );

  always #5 clk = ~clk;

  function automatic int min_i(input int a, input int b);
    return (a > b) ? b : a;
  endfunction

  function automatic int preset_cs(input logic [15:0] p);
    int mt, mo, st, so;
    mt = min_i(int'(p[15:12]), MMT);
    mo = min_i(int'(p[11:8]), 9);
    st = min_i(int'(p[7:4]), 5);
    so = min_i(int'(p[3:0]), 9);
    return ((mt * 10 + mo) * 60 + st * 10 + so) * 100;
  endfunction

  function automatic logic [23:0] to_bcd(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic check_val(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model; runs once per clock.
  task automatic compare_all();
    check_val("digits", digits, to_bcd(model_cs));
    check_val("at_zero", {23'b0, at_zero}, {23'b0, model_cs == 0});
    check_val("wrap", {23'b0, wrap}, {23'b0, model_wrap});
    check_val("expired", {23'b0, expired}, {23'b0, model_exp});
    wrap_seen += int'(wrap);
    exp_seen  += int'(expired);
  endtask

  task automatic cyc(input bit c_rst, input bit c_clr, input bit c_ld, input bit c_tick,
                     input bit c_dir, input bit c_state, input logic [15:0] c_preset);
    rst = c_rst; clr = c_clr; ld = c_ld; clks100 = c_tick;
    dir = c_dir; sw_state = c_state; preset = c_preset;
    @(posedge clk);
    model_wrap = 0;
    model_exp  = 0;
    if (c_rst || c_clr) begin
      model_cs = 0;
    end else if (c_ld) begin
      model_cs = preset_cs(c_preset);
    end else if (c_tick && c_state) begin
      if (!c_dir) begin
        model_wrap = (model_cs == MAX_CS);
        model_cs   = (model_cs + 1) % (MAX_CS + 1);
      end else if (model_cs > 0) begin
        model_cs  = model_cs - 1;
        model_exp = (model_cs == 0);
      end
    end
    #1;
    compare_all();
    $display("cyc rst=%0b clr=%0b ld=%0b tick=%0b dir=%0b run=%0b preset=%h -> digits=%h z=%0b w=%0b e=%0b",
             c_rst, c_clr, c_ld, c_tick, c_dir, c_state, c_preset, digits, at_zero, wrap, expired);
  endtask

  // Issue n qualifying ticks with random idle gaps between them.
  task automatic ticks(input int n, input bit d, input bit run);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) cyc(0, 0, 0, 0, d, run, 16'h0000);
      cyc(0, 0, 0, 1, d, run, 16'h0000);
    end
  endtask

  initial begin
    int w0, e0;
    rst = 1; clr = 0; ld = 0; clks100 = 0; dir = 0; sw_state = 0; preset = '0;
    cyc(1, 0, 0, 0, 0, 0, 16'h0000);
    cyc(1, 0, 0, 1, 0, 1, 16'h0000);
    check_val("reset_digits", digits, 24'h000000);
    check_val("reset_zero", {23'b0, at_zero}, 24'h000001);

    ticks(150, 0, 1);
    check_val("up150", digits, 24'h000150);
    check_val("up150_nz", {23'b0, at_zero}, 24'h000000);

    w0 = wrap_seen;
    cyc(0, 0, 1, 0, 0, 1, 16'h5959);
    ticks(99, 0, 1);
    check_val("max_reached", digits, 24'h595999);
    ticks(1, 0, 1);
    check_val("wrap_pulse", {23'b0, wrap}, 24'h000001);
    check_val("wrap_digits", digits, 24'h000000);
    cyc(0, 0, 0, 0, 0, 1, 16'h0000);
    check_val("wrap_count", 24'(wrap_seen - w0), 24'd1);

    e0 = exp_seen;
    cyc(0, 0, 1, 0, 1, 1, 16'h0001);
    ticks(100, 1, 1);
    check_val("down_zero", digits, 24'h000000);
    ticks(10, 1, 1);
    check_val("hold_zero", digits, 24'h000000);
    check_val("exp_count", 24'(exp_seen - e0), 24'd1);

    cyc(0, 0, 1, 0, 0, 1, 16'hFA7C);
    check_val("sat_preset", digits, 24'h595900);

    cyc(0, 0, 1, 0, 0, 1, 16'h1234);
    ticks(56, 0, 1);
    check_val("at_123456", digits, 24'h123456);
    cyc(0, 1, 1, 1, 0, 1, 16'h0742);
    check_val("clr_wins", digits, 24'h000000);
    cyc(0, 0, 1, 1, 0, 1, 16'h0742);
    check_val("ld_wins", digits, 24'h074200);

    cyc(0, 0, 1, 0, 0, 1, 16'h0010);
    ticks(50, 0, 0);
    check_val("paused", digits, 24'h001000);

    cyc(0, 0, 1, 0, 0, 1, 16'h0321);
    ticks(45, 0, 1);
    check_val("at_032145", digits, 24'h032145);
    cyc(1, 0, 0, 1, 0, 1, 16'h0000);
    check_val("rst_mid", digits, 24'h000000);
    check_val("rst_mid_zero", {23'b0, at_zero}, 24'h000001);

    // Reset coinciding with a wrap tick must suppress the pulse.
    cyc(0, 0, 1, 0, 0, 1, 16'h5959);
    ticks(99, 0, 1);
    cyc(1, 0, 0, 1, 0, 1, 16'h0000);
    check_val("rst_no_wrap", {23'b0, wrap}, 24'h000000);

    for (int i = 0; i < 4000; i++) begin
      bit r_rst, r_clr, r_ld, r_tick, r_dir, r_run;
      logic [15:0] p;
      int sel;
      r_rst  = ($urandom_range(0, 299) == 0);
      r_clr  = ($urandom_range(0, 79) == 0);
      r_ld   = ($urandom_range(0, 59) == 0);
      r_tick = ($urandom_range(0, 1) == 0);
      r_dir  = (i / 500) % 2 == 1 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      r_run  = ($urandom_range(0, 7) != 0);
      sel = int'($urandom_range(0, 3));
      p = 16'($urandom);
      if (sel == 0) p = 16'h5959;
      if (sel == 1) p = 16'h0000;
      cyc(r_rst, r_clr, r_ld, r_tick, r_dir, r_run, p);
      if (r_ld && sel == 0 && !r_rst && !r_clr) begin
        // Walk straight to the roll-over point so wraps are exercised.
        ticks(int'($urandom_range(95, 102)), 0, 1);
      end
      if (r_ld && sel == 1 && !r_rst && !r_clr) begin
        cyc(0, 0, 1, 0, 1, 1, 16'h0001);
        ticks(int'($urandom_range(98, 104)), 1, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

BCD stopwatch datapath for the timer/stopwatch design. It counts MM:SS.cc in centisecond steps on each 100 Hz enable pulse and consumes the controller's stopwatch commands: clear, load, direction and run/stop. It feeds the seven-segment display driver with six BCD digits and status flags. Counting runs up with wrap-around, or down with saturation at zero.

## Interface
- `MM_MAX_TENS`, default 5: max tens digit of minutes (59 min ceiling).
- `clk` in 1: system clock (100 MHz).
- `rst` in 1: synchronous, active-high reset.
- `clks100` in 1: one-cycle 100 Hz count enable.
- `clr` in 1: one-cycle clear pulse.
- `ld` in 1: one-cycle load pulse.
- `dir` in 1: count direction (0 = up, 1 = down), level.
- `state` in 1: run enable (1 = running, 0 = paused), level.
- `preset` in 16: BCD preset {mm_t, mm_o, ss_t, ss_o}, from switches.
- `digits` out 24: BCD {mm_t, mm_o, ss_t, ss_o, cc_t, cc_o}.
- `at_zero` out 1: digits == 00:00.00.
- `wrap` out 1: one-cycle pulse when an up-count wraps 59:59.99 -> 00:00.00.
- `expired` out 1: one-cycle pulse when a down-count reaches 00:00.00.

## Operation
- Reset values: `digits` = 0, `at_zero` = 1, `wrap` = 0, `expired` = 0.
- Per-cycle priority: rst > clr > ld > count.
- clr: `digits` <- 0. No `wrap`/`expired` pulse.
- ld: mm/ss <- `preset`, cc <- 00.
  - Illegal preset digits saturate: any ones digit >9 -> 9; ss_t >5 -> 5; mm_t > `MM_MAX_TENS` -> `MM_MAX_TENS`.
- Count happens only when `clks100` = 1, `state` = 1, and no clr/ld in that cycle.
- Up (`dir`=0):
  - cc_o increments. Carries ripple cc_o 9->0, cc_t 9->0, ss_o 9->0, ss_t 5->0, mm_o 9->0, mm_t `MM_MAX_TENS`->0.
  - A full carry-out asserts `wrap` for one cycle.
- Down (`dir`=1):
  - Borrows ripple mirror-wise (0 -> 9 or 5).
  - Transition into zero asserts `expired` for one cycle.
  - At zero, further down ticks hold at zero with no pulse; no wrap to 59:59.99.
- `dir` or `state` changes take effect on the next qualifying tick. No internal state latches them.
- `at_zero` is combinational from the registered `digits`.

## Timing
- Tick at cycle N updates `digits` at N+1. `wrap`/`expired` are registered, aligned with that update, high exactly one cycle.
- clr/ld at cycle N: `digits` is valid at N+1.
- clr and ld in the same cycle: clear wins.
- ld and tick in the same cycle: load wins, the tick is dropped.
- rst mid-count: all outputs return to reset values at the next edge. A pending pulse is suppressed.
- Ticks arriving while `state`=0 are discarded. They are not accumulated.
- Max carry chain is six digits, combinational within one cycle.

## Structure
- Shared package `stopwatch_pkg`:
  - `bcd_t` (4-bit digit) typedef.
  - Constants `BCD_MAX` = 9, `SEX_MAX` = 5.
  - Digit index constants for `digits` packing.
- Sub-module `bcd_digit`: one digit with max-value parameter, up/down.
  - Inputs: `en`, `carry_in`/`borrow_in`, `clr`, `ld`, `ld_val`.
  - Outputs: `value`, plus `carry_out` (at max and counting up) and `borrow_out` (at 0 and counting down).
- Top instantiates six `bcd_digit` cells in a chain, plus preset saturation, zero detect and pulse registers.

## Test plan
- Reset then 150 ticks, `state`=1, `dir`=0 -> `digits` = 00:01.50; `at_zero`=0; no pulses.
- `ld` with `preset`=16'h5959, 100 up ticks -> 59:59.99 after 99 ticks; 100th -> 00:00.00, `wrap` high exactly one cycle, `at_zero`=1.
- `ld` with `preset`=16'h0001, `dir`=1, 100 ticks -> 00:00.00, `expired` pulses once; 10 more ticks -> still 00:00.00, no pulse.
- `preset`=16'hFA7C loaded -> `digits` = 59:59.00 (saturation: F->5, A->9, 7->5, C->9).
- `clr`, `ld` and `clks100` all high in one cycle from 12:34.56 -> 00:00.00 next cycle; `ld`+tick only -> preset value, cc=00.
- `state`=0 for 50 ticks at 00:10.00 -> unchanged; rst asserted mid-run at 03:21.45 -> 00:00.00, `at_zero`=1, no pulses.
